cbus_arbiter: RTL
=================

# cbus_arbiter

Arbitrates between several cache-side cbus masters (instruction cache, data cache) and drives the single memory-side cbus port. It sits directly downstream of the data cache's cbus request output and upstream of the memory/AXI bridge. Once a master is granted, the arbiter locks onto it for the entire burst and switches only after the final beat handshake. The arbiter holds the grant and does not buffer data.

## Interface
- `NUM_REQ`, default 2: number of upstream cbus masters (2..8); index 0 is the data cache, index 1 is the instruction cache.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ireqs` in `cbus_req_t [NUM_REQ]`: upstream requests (`valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`).
- `iresps` out `cbus_resp_t [NUM_REQ]`: upstream responses (`ready`, `last`, `data`).
- `oreq` out `cbus_req_t`: request to memory side.
- `oresp` in `cbus_resp_t`: response from memory side.

## Operation
- States: IDLE and BUSY. Registers: `busy`, `sel` (width clog2(NUM_REQ)), `last_sel`.
- IDLE:
  - `oreq` is all-zero (`valid`=0).
  - All `iresps` are zero.
  - If any `ireqs[i].valid`, capture the winner into `sel` and go to BUSY next cycle.
- BUSY:
  - `oreq` = `ireqs[sel]`, passed combinationally.
  - `iresps[sel]` = `oresp`; all other `iresps` are zero.
  - A beat completes when `oresp.ready` is 1 in a cycle where `oreq.valid` is 1.
  - A beat with `oresp.last`=1 returns to IDLE and sets `last_sel` <= `sel`.
- Masters must hold `valid` and all request fields stable from assertion until their `last` beat. If a master drops `valid` mid-burst, the arbiter stays in BUSY, keeps forwarding (`oreq.valid`=0), and leaves BUSY only on a `last` handshake.
- Non-granted masters see `ready`=0 and simply wait; no request is ever dropped.
- Arithmetic: round-robin index = (`last_sel` + 1 + k) mod `NUM_REQ` for k = 0..NUM_REQ-1; the first valid in that order wins.

## Timing
- Reset values: `busy`=0, `sel`=0, `last_sel`=`NUM_REQ`-1. Consequently `oreq`=0 and every `iresps[i]`=0 immediately after reset.
- Grant latency: a request first asserted at cycle t appears on `oreq` at cycle t+1, provided the arbiter is IDLE at t.
- Data path: `oresp`→`iresps[sel]` and `ireqs[sel]`→`oreq` are zero-latency combinational paths in BUSY.
- Back-to-back bursts: after the `last` handshake at cycle t, the arbiter is IDLE at t+1 and the next grant is forwarded at t+2. This is exactly one bubble cycle.
- Simultaneous events:
  - A new request arriving during BUSY is ignored until IDLE.
  - A `last` handshake and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
- Reset mid-burst: return to IDLE and drop `oreq.valid` on the next edge. The downstream side shares the same reset, so there is no partial-burst recovery.
- `len`=0 (single beat): BUSY lasts exactly until the first `ready`&&`last` handshake.

## Configuration
- `CBUS_ARBITER_RR_EN` defined: round-robin priority starting after `last_sel`, so no master starves.
- Not defined: fixed priority, lowest index wins (data cache over instruction cache). In this mode `last_sel` is neither used nor updated, and synthesis may remove it.

## Test plan
- Reset, then idle: `reset`=1 for 2 cycles, no requests → `oreq.valid`=0 and all `iresps`=0 every cycle.
- Single master: `ireqs[0]` read, `addr`=0x8000_0040, `len`=3, memory gives `ready` every cycle → `oreq` mirrors request from t+1, `iresps[0]` sees 4 beats with `last` on the 4th, and the arbiter is IDLE the cycle after.
- Lock during burst: master 0 is BUSY with a 4-beat burst; master 1 asserts a request at beat 2 → `iresps[1].ready` stays 0 until master 0's `last`, then master 1 is granted with exactly one bubble.
- Simultaneous requests, repeated:
  - With `CBUS_ARBITER_RR_EN`: grants alternate 0,1,0,1.
  - Without it: master 0 is granted every time while it keeps re-requesting.
- Backpressure: `oresp.ready` toggles 1,0,0,1,… during an 8-beat write (`strobe`=0xF) → every beat is forwarded exactly once, and the arbiter stays in BUSY through the stall cycles.
- Reset mid-burst: assert `reset` at beat 2 of 4 → next cycle `oreq.valid`=0 and state is IDLE; a fresh request after reset is granted with 1-cycle latency.

Source files
------------

// File: rtl/cbus_arbiter_if.sv
// cbus request/response types and the bundled port interface of cbus_arbiter.
// master modport is the arbiter's view; slave modport is the caches/memory side.
package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [7:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

interface cbus_arbiter_if #(parameter int NUM_REQ = 2);
   cbus_pkg::cbus_req_t  [NUM_REQ-1:0] ireqs;
   cbus_pkg::cbus_resp_t [NUM_REQ-1:0] iresps;
   cbus_pkg::cbus_req_t                oreq;
   cbus_pkg::cbus_resp_t               oresp;

   modport master (input ireqs, output iresps, output oreq, input oresp);
   modport slave  (output ireqs, input iresps, input oreq, output oresp);
endinterface

// File: rtl/cbus_arbiter.sv
// Burst-locking cbus arbiter: one upstream master owns the memory port until its last beat.
// Define CBUS_ARBITER_RR_EN for round-robin priority; otherwise lowest index wins.
module cbus_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic           clk,
   input  logic           reset,
   cbus_arbiter_if.master bus
);
   localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W-1:0] cand_idx;
   logic             grant_found;
   logic             beat_done;
   logic             last_done;
`ifdef CBUS_ARBITER_RR_EN
   logic [SEL_W-1:0] last_sel_q, last_sel_d;
`endif

   // First valid requester in priority order; only consulted while IDLE.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CBUS_ARBITER_RR_EN
         cand_idx = SEL_W'((int'(last_sel_q) + 1 + k) % NUM_REQ);
`else
         cand_idx = SEL_W'(k);
`endif
         if (!grant_found && bus.ireqs[cand_idx].valid) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // Zero-latency forwarding in both directions for the locked master.
   always_comb begin
      bus.oreq   = '0;
      bus.iresps = '0;
      if (state_q == BUSY) begin
         bus.oreq          = bus.ireqs[sel_q];
         bus.iresps[sel_q] = bus.oresp;
      end
   end

   assign beat_done = (state_q == BUSY) && bus.oreq.valid && bus.oresp.ready;
   assign last_done = beat_done && bus.oresp.last;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
`ifdef CBUS_ARBITER_RR_EN
      last_sel_d = last_sel_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               state_d = BUSY;
               sel_d   = grant_idx;
            end
         end
         BUSY: begin
            // A master that drops valid mid-burst cannot handshake, so the lock holds.
            if (last_done) begin
               state_d = IDLE;
`ifdef CBUS_ARBITER_RR_EN
               last_sel_d = sel_q;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
`ifdef CBUS_ARBITER_RR_EN
         last_sel_q <= SEL_W'(NUM_REQ - 1);
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
`ifdef CBUS_ARBITER_RR_EN
         last_sel_q <= last_sel_d;
`endif
      end
   end
endmodule
